// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the control sequencer. These are the
//                opcodes, the one-hot bus-select codes, the microstep
//                encoding and the bit layout of the control word.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  localparam int OPC_W  = 4;
  localparam int STEP_W = 3;

  // Opcodes, taken from instr[7:4]
  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_STA = 4'd4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'd5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'd7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'd8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'd14;
  localparam logic [OPC_W-1:0] OP_HLT = 4'd15;

  // One-hot bus driver selects
  localparam logic [5:0] BUS_MEM   = 6'd1;
  localparam logic [5:0] BUS_A     = 6'd2;
  localparam logic [5:0] BUS_B     = 6'd4;
  localparam logic [5:0] BUS_E     = 6'd8;
  localparam logic [5:0] BUS_PC    = 6'd16;
  localparam logic [5:0] BUS_INSTR = 6'd32;

  // Microsteps
  typedef enum logic [STEP_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Control word layout: bus select in the low bits, then strobes, then
  // the internal halt request.
  localparam int CW_BUS_LSB  = 0;
  localparam int CW_BUS_MSB  = 5;
  localparam int CW_MAR_IN   = 6;
  localparam int CW_IR_IN    = 7;
  localparam int CW_PC_INC   = 8;
  localparam int CW_PC_IN    = 9;
  localparam int CW_A_IN     = 10;
  localparam int CW_B_IN     = 11;
  localparam int CW_MEM_WE   = 12;
  localparam int CW_ALU_SUB  = 13;
  localparam int CW_FLAGS_IN = 14;
  localparam int CW_OUT_IN   = 15;
  localparam int CW_HALT     = 16;
  localparam int CW_W        = 17;

endpackage
`default_nettype wire

// File: rtl/microcode_rom.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_rom
//  Description : Combinational microcode table. It maps the opcode, the
//                microstep and the flags to a control word, and flags the
//                final step of each instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_rom
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  step_t            step,
  input  logic             carry_flag,
  input  logic             zero_flag,
  output logic [CW_W-1:0]  ctrl_word,
  output logic             last_step
);

  // Decode the control word for the current step; flags only matter at T2
  always_comb begin
    ctrl_word = '0;
    last_step = 1'b0;
    unique case (step)
      T0: begin
        ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_PC;
        ctrl_word[CW_MAR_IN]             = 1'b1;
      end
      T1: begin
        ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_MEM;
        ctrl_word[CW_IR_IN]              = 1'b1;
        ctrl_word[CW_PC_INC]             = 1'b1;
        // NOP and the undefined opcodes 9..13 finish after the fetch
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
          OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 1'b0;
          default:                              last_step = 1'b1;
        endcase
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_INSTR;
            ctrl_word[CW_MAR_IN]             = 1'b1;
          end
          OP_LDI: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_INSTR;
            ctrl_word[CW_A_IN]               = 1'b1;
            last_step                        = 1'b1;
          end
          OP_JMP: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_INSTR;
            ctrl_word[CW_PC_IN]              = 1'b1;
            last_step                        = 1'b1;
          end
          OP_JC, OP_JZ: begin
            // A jump not taken drives nothing and simply ends the instruction
            if ((opcode == OP_JC) ? carry_flag : zero_flag) begin
              ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_INSTR;
              ctrl_word[CW_PC_IN]              = 1'b1;
            end
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_A;
            ctrl_word[CW_OUT_IN]             = 1'b1;
            last_step                        = 1'b1;
          end
          OP_HLT: begin
            ctrl_word[CW_HALT] = 1'b1;
            last_step          = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_MEM;
            ctrl_word[CW_A_IN]               = 1'b1;
            last_step                        = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_MEM;
            ctrl_word[CW_B_IN]               = 1'b1;
            ctrl_word[CW_ALU_SUB]            = (opcode == OP_SUB);
          end
          OP_STA: begin
            ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_A;
            ctrl_word[CW_MEM_WE]             = 1'b1;
            last_step                        = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl_word[CW_BUS_MSB:CW_BUS_LSB] = BUS_E;
          ctrl_word[CW_A_IN]               = 1'b1;
          ctrl_word[CW_FLAGS_IN]           = 1'b1;
          ctrl_word[CW_ALU_SUB]            = (opcode == OP_SUB);
        end
        last_step = 1'b1;
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Microstep controller for the 8-bit computer. It holds the
//                step counter and the halt state, and it gates the decoded
//                control word with run/halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic [5:0] out_signals,
  output logic       mar_in,
  output logic       ir_in,
  output logic       pc_inc,
  output logic       pc_in,
  output logic       a_in,
  output logic       b_in,
  output logic       mem_we,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halted,
  output logic [2:0] step
);

  step_t            r_step;
  step_t            w_step_next;
  logic             r_halted;
  logic             w_halted_next;
  logic [CW_W-1:0]  w_ctrl_word;
  logic [CW_W-1:0]  w_ctrl_gated;
  logic             w_last_step;
  logic             w_active;
  logic             w_unused_operand;

  // The operand nibble is consumed by the datapath, not by the sequencer
  assign w_unused_operand = ^instr[3:0];

  microcode_rom u_rom (
    .opcode     (instr[7:4]),
    .step       (r_step),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl_word  (w_ctrl_word),
    .last_step  (w_last_step)
  );

  // Step counter and halt flag; reset has priority over run and halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_next;
      r_halted <= w_halted_next;
    end
  end

  // Next step, halt entry and output gating
  always_comb begin
    w_step_next   = r_step;
    w_halted_next = r_halted;
    w_active      = run && !r_halted;
    w_ctrl_gated  = w_active ? w_ctrl_word : '0;
    if (w_active) begin
      if (w_ctrl_word[CW_HALT]) begin
        w_halted_next = 1'b1;
        w_step_next   = T0;
      end else if (w_last_step) begin
        w_step_next = T0;
      end else begin
        w_step_next = step_t'(r_step + 3'd1);
      end
    end
  end

  assign out_signals = w_ctrl_gated[CW_BUS_MSB:CW_BUS_LSB];
  assign mar_in      = w_ctrl_gated[CW_MAR_IN];
  assign ir_in       = w_ctrl_gated[CW_IR_IN];
  assign pc_inc      = w_ctrl_gated[CW_PC_INC];
  assign pc_in       = w_ctrl_gated[CW_PC_IN];
  assign a_in        = w_ctrl_gated[CW_A_IN];
  assign b_in        = w_ctrl_gated[CW_B_IN];
  assign mem_we      = w_ctrl_gated[CW_MEM_WE];
  assign alu_sub     = w_ctrl_gated[CW_ALU_SUB];
  assign flags_in    = w_ctrl_gated[CW_FLAGS_IN];
  assign out_in      = w_ctrl_gated[CW_OUT_IN];
  assign halted      = r_halted;
  assign step        = r_step;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Scoreboard bench for control_sequencer. The driver expands
//                each instruction into its list of microsteps and pushes the
//                expected outputs. The monitor pops and compares them once
//                per cycle and checks the bus one-hot invariant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, carry_flag, zero_flag;
  logic [7:0] instr;
  logic [5:0] out_signals;
  logic       mar_in, ir_in, pc_inc, pc_in, a_in, b_in, mem_we;
  logic       alu_sub, flags_in, out_in, halted;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instr       (instr),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .out_signals (out_signals),
    .mar_in      (mar_in),
    .ir_in       (ir_in),
    .pc_inc      (pc_inc),
    .pc_in       (pc_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .mem_we      (mem_we),
    .alu_sub     (alu_sub),
    .flags_in    (flags_in),
    .out_in      (out_in),
    .halted      (halted),
    .step        (step)
  );

  // Strobe bits of the bench's own expected-word layout
  localparam logic [9:0] S_MAR  = 10'd1;
  localparam logic [9:0] S_IR   = 10'd2;
  localparam logic [9:0] S_PCI  = 10'd4;
  localparam logic [9:0] S_PCIN = 10'd8;
  localparam logic [9:0] S_A    = 10'd16;
  localparam logic [9:0] S_B    = 10'd32;
  localparam logic [9:0] S_WE   = 10'd64;
  localparam logic [9:0] S_SUB  = 10'd128;
  localparam logic [9:0] S_FL   = 10'd256;
  localparam logic [9:0] S_OUT  = 10'd512;

  logic [15:0] prog[$];
  logic [19:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          started = 1'b0;

  function automatic logic [15:0] me(logic [5:0] bus, logic [9:0] s);
    return {s, bus};
  endfunction

  // Expected microstep sequence of one instruction, straight from the opcode table
  function automatic void build_prog(logic [3:0] op, bit c, bit z);
    prog.delete();
    prog.push_back(me(6'd16, S_MAR));
    prog.push_back(me(6'd1, S_IR | S_PCI));
    case (op)
      4'd1: begin prog.push_back(me(6'd32, S_MAR)); prog.push_back(me(6'd1, S_A)); end
      4'd2: begin
        prog.push_back(me(6'd32, S_MAR)); prog.push_back(me(6'd1, S_B));
        prog.push_back(me(6'd8, S_A | S_FL));
      end
      4'd3: begin
        prog.push_back(me(6'd32, S_MAR)); prog.push_back(me(6'd1, S_B | S_SUB));
        prog.push_back(me(6'd8, S_A | S_FL | S_SUB));
      end
      4'd4: begin prog.push_back(me(6'd32, S_MAR)); prog.push_back(me(6'd2, S_WE)); end
      4'd5: prog.push_back(me(6'd32, S_A));
      4'd6: prog.push_back(me(6'd32, S_PCIN));
      4'd7: prog.push_back(c ? me(6'd32, S_PCIN) : 16'h0);
      4'd8: prog.push_back(z ? me(6'd32, S_PCIN) : 16'h0);
      4'd14: prog.push_back(me(6'd2, S_OUT));
      4'd15: prog.push_back(16'h0);
      default: ;
    endcase
  endfunction

  // One clock of stimulus plus its expected response
  task automatic cyc(bit r, bit rn, logic [7:0] ins, bit c, bit z, logic [19:0] e);
    rst = r; run = rn; instr = ins; carry_flag = c; zero_flag = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Run one instruction, optionally freezing at a step or resetting at a step
  task automatic run_instr(logic [7:0] ins, bit c, bit z, int freeze_at, int freeze_len,
                           int rst_at, output bit now_halted);
    now_halted = 1'b0;
    build_prog(ins[7:4], c, z);
    for (int i = 0; i < prog.size(); i++) begin
      bit cc, zz;
      cc = (i == 2) ? c : 1'($urandom_range(0, 1));
      zz = (i == 2) ? z : 1'($urandom_range(0, 1));
      if (i == freeze_at)
        for (int k = 0; k < freeze_len; k++) cyc(1'b0, 1'b0, ins, cc, zz, {1'b0, 3'(i), 16'h0});
      if (i == rst_at) begin
        cyc(1'b1, 1'b1, ins, cc, zz, {1'b0, 3'(i), prog[i]});
        return;
      end
      cyc(1'b0, 1'b1, ins, cc, zz, {1'b0, 3'(i), prog[i]});
    end
    now_halted = (ins[7:4] == 4'hF);
  endtask

  // Stay halted for n cycles whatever the inputs, then leave through reset
  task automatic halt_phase(int n);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), {1'b1, 3'd0, 16'h0});
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, {1'b1, 3'd0, 16'h0});
  endtask

  // Monitor: compare every cycle against the scoreboard and check invariants
  always @(negedge clk) begin
    if (started) begin
      logic [19:0] act, e;
      act = {halted, step, out_in, flags_in, alu_sub, mem_we, b_in, a_in,
             pc_in, pc_inc, ir_in, mar_in, out_signals};
      total++;
      if ($countones(out_signals) > 1) begin
        bad++;
        $display("FAIL onehot t=%0t out_signals=%b required popcount<=1", $time, out_signals);
      end
      total++;
      if (pc_inc && pc_in) begin
        bad++;
        $display("FAIL pc_excl t=%0t pc_inc=1 pc_in=1 required not both", $time);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL cycle t=%0t actual={h%b st%0d strb%b bus%0d} required={h%b st%0d strb%b bus%0d}",
                   $time, act[19], act[18:16], act[15:6], act[5:0],
                   e[19], e[18:16], e[15:6], e[5:0]);
        end
      end
    end
  end

  initial begin
    bit h;
    rst = 1'b1; run = 1'b1; instr = 8'h00; carry_flag = 1'b0; zero_flag = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;
    // second reset cycle: T0 decode visible
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, {1'b0, 3'd0, me(6'd16, S_MAR)});

    // directed instructions
    run_instr(8'h57, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'h2E, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'h3E, 1'b1, 1'b0, -1, 0, -1, h);
    run_instr(8'h73, 1'b1, 1'b0, -1, 0, -1, h);
    run_instr(8'h73, 1'b0, 1'b1, -1, 0, -1, h);
    run_instr(8'h83, 1'b0, 1'b1, -1, 0, -1, h);
    run_instr(8'h83, 1'b1, 1'b0, -1, 0, -1, h);
    run_instr(8'h1A, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'h4B, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'h6C, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'hE0, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'h00, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'h9F, 1'b0, 1'b0, -1, 0, -1, h);
    run_instr(8'hD1, 1'b1, 1'b1, -1, 0, -1, h);
    // freeze at ADD T3 for 4 cycles, then reset at ADD T3
    run_instr(8'h2E, 1'b0, 1'b0, 3, 4, -1, h);
    run_instr(8'h2E, 1'b0, 1'b0, -1, 0, 3, h);
    // halt, hold for 20 cycles, recover through reset
    run_instr(8'hF0, 1'b0, 1'b0, -1, 0, -1, h);
    if (h) halt_phase(20);

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      logic [3:0] op;
      int         fa, ra;
      op = (n % 50 == 49) ? 4'hF : 4'($urandom_range(0, 14));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr({op, 4'($urandom)}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                fa, int'($urandom_range(1, 4)), ra, h);
      if (h) halt_phase(int'($urandom_range(2, 8)));
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
